// File: rtl/video_fmt_lock_pkg.sv
// Shared state encoding for the frame-format lock controller and its downstream consumers.
package video_fmt_lock_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_LOCKED  = 3'd4
  } fmt_state_e;

endpackage

// File: rtl/video_fmt_lock_de_run_meter.sv
// Per-frame DE statistics: line count, reference run width, consistency and saturation.
// Frame results are combinational and meaningful in the i_vclr cycle.
module video_fmt_lock_de_run_meter #(
  parameter int unsigned P_HCNT = 11,
  parameter int unsigned P_VCNT = 11
) (
  input  logic              i_clk,
  input  logic              i_xres,
  input  logic              i_de,
  input  logic              i_vclr,
  output logic [P_HCNT-1:0] o_width_c,
  output logic [P_VCNT-1:0] o_height_c,
  output logic              o_valid_c
);

  localparam logic [P_HCNT-1:0] RUN_MAX  = '1;
  localparam logic [P_VCNT-1:0] LINE_MAX = '1;

  logic              de_q, de_d;
  logic [P_HCNT-1:0] run_q, run_d;
  logic [P_HCNT-1:0] ref_q, ref_d;
  logic              first_q, first_d;
  logic [P_VCNT-1:0] line_q, line_d;
  logic              bad_q, bad_d;
  logic              discard_q, discard_d;

  logic rise, fall, open_run, close_run, mismatch;

  always_comb begin
    rise      = i_de & ~de_q;
    fall      = ~i_de & de_q;
    open_run  = i_de & de_q;
    // A run that straddled the previous i_vclr is ignored when it closes.
    close_run = fall & ~discard_q;
    mismatch  = close_run & ~first_q & (run_q != ref_q);

    o_width_c  = (close_run & first_q) ? run_q : ref_q;
    o_height_c = line_q;
    o_valid_c  = (line_q != '0) & ~(bad_q | mismatch) & ~open_run;
  end

  always_comb begin
    de_d      = i_de;
    run_d     = run_q;
    ref_d     = ref_q;
    first_d   = first_q;
    line_d    = line_q;
    bad_d     = bad_q;
    discard_d = discard_q;

    if (rise) begin
      run_d = P_HCNT'(1);
    end else if (i_de) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + P_HCNT'(1);
    end else begin
      run_d = '0;
    end

    if (rise) begin
      line_d = (line_q == LINE_MAX) ? line_q : line_q + P_VCNT'(1);
    end

    if (close_run) begin
      if (first_q) begin
        ref_d   = run_q;
        first_d = 1'b0;
      end else if (mismatch) begin
        bad_d = 1'b1;
      end
    end
    if (fall) begin
      discard_d = 1'b0;
    end

    if ((i_de & ~discard_q & (run_d == RUN_MAX)) | (line_d == LINE_MAX)) begin
      bad_d = 1'b1;
    end

    // Restart for the new frame; a rise in this cycle is its first line.
    if (i_vclr) begin
      line_d    = rise ? P_VCNT'(1) : '0;
      ref_d     = '0;
      first_d   = 1'b1;
      bad_d     = 1'b0;
      discard_d = open_run;
    end
  end

  always_ff @(posedge i_clk or negedge i_xres) begin
    if (!i_xres) begin
      de_q      <= 1'b0;
      run_q     <= '0;
      ref_q     <= '0;
      first_q   <= 1'b1;
      line_q    <= '0;
      bad_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      de_q      <= de_d;
      run_q     <= run_d;
      ref_q     <= ref_d;
      first_q   <= first_d;
      line_q    <= line_d;
      bad_q     <= bad_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/video_fmt_lock.sv
// Frame-format lock controller: locks after P_LOCK_FRAMES consecutive identical valid frames.
module video_fmt_lock
  import video_fmt_lock_pkg::*;
#(
  parameter int unsigned P_HCNT        = 11,
  parameter int unsigned P_VCNT        = 11,
  parameter int unsigned P_LOCK_FRAMES = 3,
  parameter int unsigned P_TO_BITS     = 24
) (
  input  logic               i_clk,
  input  logic               i_xres,
  input  logic               i_en,
  input  logic               i_de,
  input  logic               i_vclr,
  output logic               o_lock,
  output logic [P_HCNT-1:0]  o_width,
  output logic [P_VCNT-1:0]  o_height,
  output logic               o_chg,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned    MATCH_W = 4;
  localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(P_LOCK_FRAMES);
  localparam logic [P_TO_BITS-1:0] TO_MAX = '1;

  logic [P_HCNT-1:0] frm_width_c;
  logic [P_VCNT-1:0] frm_height_c;
  logic              frm_valid_c;

  video_fmt_lock_de_run_meter #(
    .P_HCNT (P_HCNT),
    .P_VCNT (P_VCNT)
  ) u_meter (
    .i_clk      (i_clk),
    .i_xres     (i_xres),
    .i_de       (i_de),
    .i_vclr     (i_vclr),
    .o_width_c  (frm_width_c),
    .o_height_c (frm_height_c),
    .o_valid_c  (frm_valid_c)
  );

  fmt_state_e          state_q, state_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [P_HCNT-1:0]   cand_w_q, cand_w_d;
  logic [P_VCNT-1:0]   cand_h_q, cand_h_d;
  logic [P_HCNT-1:0]   width_q, width_d;
  logic [P_VCNT-1:0]   height_q, height_d;
  logic                lock_q, lock_d;
  logic                chg_q, chg_d;
  logic [P_TO_BITS-1:0] to_q, to_d;

  logic timeout, same, take_cand, load_out;

  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    cand_w_d  = cand_w_q;
    cand_h_d  = cand_h_q;
    width_d   = width_q;
    height_d  = height_q;
    take_cand = 1'b0;
    load_out  = 1'b0;

    // Counts cycles since the last i_vclr, the i_vclr cycle itself being zero.
    to_d    = i_vclr ? P_TO_BITS'(1) : to_q + P_TO_BITS'(1);
    timeout = (to_q == TO_MAX) & ~i_vclr;
    same    = (frm_width_c == cand_w_q) & (frm_height_c == cand_h_q);

    if (!i_en) begin
      state_d = ST_IDLE;
      match_d = '0;
      to_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          to_d    = '0;
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (i_vclr) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (i_vclr) begin
            if (frm_valid_c) take_cand = 1'b1;
          end else if (timeout) begin
            state_d = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (i_vclr) begin
            if (frm_valid_c && same) begin
              match_d = match_q + MATCH_W'(1);
              if (match_d == LOCK_N) begin
                state_d  = ST_LOCKED;
                load_out = 1'b1;
              end
            end else if (frm_valid_c) begin
              take_cand = 1'b1;
            end else begin
              state_d = ST_MEASURE;
              match_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_SEARCH;
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          if (i_vclr) begin
            if (frm_valid_c && !same) begin
              take_cand = 1'b1;
            end else if (!frm_valid_c) begin
              state_d = ST_MEASURE;
              match_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_SEARCH;
            match_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // A fresh candidate counts as the first match; with a lock depth of one it locks at once.
      if (take_cand) begin
        cand_w_d = frm_width_c;
        cand_h_d = frm_height_c;
        match_d  = MATCH_W'(1);
        if (LOCK_N == MATCH_W'(1)) begin
          state_d  = ST_LOCKED;
          load_out = 1'b1;
        end else begin
          state_d = ST_VERIFY;
        end
      end
      if (load_out) begin
        width_d  = frm_width_c;
        height_d = frm_height_c;
      end
    end

    lock_d = (state_d == ST_LOCKED);
    chg_d  = lock_d ^ lock_q;
  end

  always_ff @(posedge i_clk or negedge i_xres) begin
    if (!i_xres) begin
      state_q  <= ST_IDLE;
      match_q  <= '0;
      cand_w_q <= '0;
      cand_h_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      lock_q   <= 1'b0;
      chg_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      cand_w_q <= cand_w_d;
      cand_h_q <= cand_h_d;
      width_q  <= width_d;
      height_q <= height_d;
      lock_q   <= lock_d;
      chg_q    <= chg_d;
      to_q     <= to_d;
    end
  end

  assign o_lock   = lock_q;
  assign o_width  = width_q;
  assign o_height = height_q;
  assign o_chg    = chg_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_video_fmt_lock.sv
// Directed bench for video_fmt_lock with an 8-bit frame timeout.
module tb_video_fmt_lock;

  logic        clk  = 1'b0;
  logic        xres = 1'b0;
  logic        en   = 1'b0;
  logic        de   = 1'b0;
  logic        vclr = 1'b0;
  logic        lock, chg;
  logic [10:0] width, height;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  video_fmt_lock #(
    .P_HCNT        (11),
    .P_VCNT        (11),
    .P_LOCK_FRAMES (3),
    .P_TO_BITS     (8)
  ) dut (
    .i_clk    (clk),
    .i_xres   (xres),
    .i_en     (en),
    .i_de     (de),
    .i_vclr   (vclr),
    .o_lock   (lock),
    .o_width  (width),
    .o_height (height),
    .o_chg    (chg),
    .o_state  (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int st, input int lk, input int ch);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".lock"},  32'(lock),  32'(lk));
    chk({tag, ".chg"},   32'(chg),   32'(ch));
  endtask

  task automatic chk_fmt(input string tag, input int w, input int h);
    chk({tag, ".width"},  32'(width),  32'(w));
    chk({tag, ".height"}, 32'(height), 32'(h));
  endtask

  task automatic step(input logic d, input logic v);
    de   = d;
    vclr = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic line(input int w);
    repeat (w) step(1'b1, 1'b0);
    idle(4);
  endtask

  task automatic lines(input int n, input int w);
    repeat (n) line(w);
  endtask

  // n lines of w pixels followed by the next frame-start pulse
  task automatic vframe(input int n, input int w);
    lines(n, w);
    step(1'b0, 1'b1);
  endtask

  initial begin
    // reset held while inputs toggle
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk_st("rst", 0, 0, 0);
    chk_fmt("rst", 0, 0);
    xres = 1'b1;
    idle(3);
    chk_st("rst_rel_en0", 0, 0, 0);

    // initial lock on 4 x 16
    en = 1'b1;
    idle(1);
    chk_st("search", 1, 0, 0);
    step(1'b0, 1'b1);
    chk_st("measure", 2, 0, 0);
    vframe(4, 16);
    chk_st("verify1", 3, 0, 0);
    vframe(4, 16);
    chk_st("verify2", 3, 0, 0);
    vframe(4, 16);
    chk_st("lock16", 4, 1, 1);
    chk_fmt("lock16", 16, 4);
    idle(1);
    chk_st("lock16_hold", 4, 1, 0);

    // format change to 20 pixels
    vframe(4, 20);
    chk_st("chg20", 3, 0, 1);
    chk_fmt("chg20_held", 16, 4);
    vframe(4, 20);
    chk_st("chg20_v2", 3, 0, 0);
    vframe(4, 20);
    chk_st("lock20", 4, 1, 1);
    chk_fmt("lock20", 20, 4);

    // bad frame during verify
    vframe(4, 16);
    chk_st("to16_v1", 3, 0, 1);
    lines(2, 16);
    line(15);
    line(16);
    step(1'b0, 1'b1);
    chk_st("badline", 2, 0, 0);
    vframe(4, 16);
    chk_st("after_bad1", 3, 0, 0);
    vframe(4, 16);
    chk_st("after_bad2", 3, 0, 0);
    vframe(4, 16);
    chk_st("after_bad3", 4, 1, 1);
    chk_fmt("after_bad3", 16, 4);

    // run closing in the i_vclr cycle belongs to the ending frame
    lines(3, 16);
    repeat (16) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk_st("fall_at_vclr_ok", 4, 1, 0);
    lines(3, 16);
    repeat (12) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk_st("fall_at_vclr_short", 2, 0, 1);
    vframe(4, 16);
    vframe(4, 16);
    vframe(4, 16);
    chk_st("relock_a", 4, 1, 1);

    // DE high across i_vclr invalidates the frame; the straddling run is dropped
    lines(3, 16);
    repeat (12) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk_st("open_at_vclr", 2, 0, 1);
    repeat (3) step(1'b1, 1'b0);
    idle(3);
    vframe(4, 16);
    chk_st("after_open", 3, 0, 0);
    vframe(4, 16);
    vframe(4, 16);
    chk_st("relock_b", 4, 1, 1);

    // timeout: no i_vclr after the locking pulse
    idle(254);
    chk_st("to_before", 4, 1, 0);
    idle(1);
    chk_st("to_fire", 1, 0, 1);
    chk_fmt("to_held", 16, 4);

    // relock, then drop enable mid-frame
    step(1'b0, 1'b1);
    chk_st("to_measure", 2, 0, 0);
    vframe(4, 16);
    vframe(4, 16);
    vframe(4, 16);
    chk_st("relock_c", 4, 1, 1);
    lines(2, 16);
    repeat (5) step(1'b1, 1'b0);
    en = 1'b0;
    step(1'b1, 1'b0);
    chk_st("en_drop", 0, 0, 1);
    idle(2);
    chk_st("en_drop_idle", 0, 0, 0);
    chk_fmt("en_drop_held", 16, 4);

    // asynchronous reset mid-cycle
    en = 1'b1;
    idle(1);
    chk_st("re_search", 1, 0, 0);
    #2 xres = 1'b0;
    #1;
    chk_st("async_rst", 0, 0, 0);
    chk_fmt("async_rst", 0, 0);
    xres = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_fmt_lock.md
# video_fmt_lock

Frame-format detector and lock controller. Sits downstream of the sync-delay/HV-counter stage: it observes DE and the frame-start pulse, measures active width (pixels/line) and height (lines/frame), and declares lock only after a configurable number of consecutive identical, well-formed frames. Lock status and measured format drive downstream scaler/buffer configuration. Format changes are reported by pulse.

## Interface
- P_HCNT, 11, width of pixel-run counter and o_width
- P_VCNT, 11, width of line counter and o_height
- P_LOCK_FRAMES, 3, consecutive matching frames required to lock (1..15)
- P_TO_BITS, 24, frame-timeout counter width; timeout = 2^P_TO_BITS − 1 cycles without i_vclr
- i_clk  in  1  pixel clock; single clock domain
- i_xres  in  1  reset; asynchronous assert, active-low
- i_en  in  1  detector enable; low forces IDLE
- i_de  in  1  data enable, aligned with i_vclr
- i_vclr  in  1  one-cycle frame-start pulse; the cycle's i_de belongs to the new frame
- o_lock  out  1  format locked
- o_width  out  P_HCNT  locked active width; holds last locked value when unlocked
- o_height  out  P_VCNT  locked active height; same hold rule
- o_chg  out  1  one-cycle pulse on any o_lock transition
- o_state  out  3  FSM state: IDLE=0, SEARCH=1, MEASURE=2, VERIFY=3, LOCKED=4

## Operation
- Line stats:
  - DE rising edge (i_de=1, previous i_de=0) increments the line count and starts a run.
  - The run counter counts DE-high cycles. On the falling edge, the first run of the frame sets the reference width; any later run that differs marks the frame bad.
  - Both counters saturate at all-ones. Saturation marks the frame bad.
  - Frame is valid iff: line count > 0, not bad, and no run open at i_vclr (previous i_de=1 at i_vclr ⇒ invalid, open run discarded).
- Evaluation at each i_vclr uses stats of the ending frame, including a run closing in that same cycle. Counters then restart for the new frame; an i_de rising edge in the i_vclr cycle counts as line 1.
- FSM transitions:
  - IDLE → SEARCH when i_en=1.
  - SEARCH → MEASURE on i_vclr. No evaluation.
  - MEASURE on i_vclr:
    - valid → store candidate W/H, match=1, VERIFY (LOCKED directly if P_LOCK_FRAMES=1).
    - invalid → stay.
  - VERIFY on i_vclr:
    - valid and equal to candidate → match+1; match=P_LOCK_FRAMES → LOCKED, load o_width/o_height.
    - valid but different → new candidate, match=1.
    - invalid → MEASURE, match=0.
  - LOCKED on i_vclr:
    - equal → stay.
    - valid but different → VERIFY with new candidate, match=1.
    - invalid → MEASURE.
  - Timeout in MEASURE/VERIFY/LOCKED → SEARCH. Timeout counter clears on every i_vclr and in IDLE.
  - i_en=0 in any state → IDLE next cycle. Highest priority over i_vclr and timeout.
- o_lock=1 iff state=LOCKED. o_chg pulses when o_lock changes for any cause, including i_en drop.

## Timing
- All outputs registered. Reset values: o_lock=0, o_width=0, o_height=0, o_chg=0, o_state=0.
- Evaluation latency: state, o_lock, o_width, o_height and o_chg update in the cycle after the sampled i_vclr (1-cycle latency).
- Timeout fires when the counter reaches its terminal value; effects are visible the next cycle.
- Reset asserted mid-frame: all state and outputs clear immediately. After release the FSM starts in IDLE.

## Structure
- A shared include holds the state-encoding localparams and o_state width; downstream config logic shares it.
- One sub-module: de_run_meter, containing edge detect, run and line counters, width-consistency check and saturation. It outputs per-frame {width, height, valid}, sampled at i_vclr. The FSM, match counter and timeout live in the top.

## Test plan
- Reset: hold i_xres=0, toggle i_de/i_vclr → all outputs 0, o_state=0. Release with i_en=0 → stays IDLE.
- Lock (P_LOCK_FRAMES=3): i_en=1, frames of 4 lines × 16 DE cycles → o_lock rises 1 cycle after the 4th i_vclr; o_width=16, o_height=4; o_chg high exactly 1 cycle.
- Format change while locked: one frame with 20-pixel lines → o_lock falls after the next i_vclr, o_chg pulse, o_state=3. Two more 20-pixel frames → relock with o_width=20.
- Bad frame: a 16-pixel frame with one 15-pixel line during VERIFY → o_state=2, match reset; lock needs 3 further good frames plus the evaluating i_vclr.
- Timeout (P_TO_BITS=8): locked, then stop i_vclr → o_lock falls at 255 cycles after the last i_vclr (+1 output latency); o_state=1; o_width held.
- Control edges:
  - i_en=0 mid-frame while locked → o_state=0 and o_lock=0 next cycle, o_chg pulse.
  - i_vclr coincident with a DE falling edge → that run is counted in the old frame.
  - DE still high at i_vclr → frame invalid.
